// File: rtl/soc_system_pio_in.sv
// Avalon-MM parallel input port for the HPS lightweight bridge.
// Synchronised, debounced inputs with edge capture and a masked level irq.
module soc_system_pio_in #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] capture_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] wr_clr;
  logic             wr_en;

  // Only sync_q[0] may go metastable; nothing else reads in_port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    logic [WIDTH-1:0] st_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        st_q <= '0;
      end else begin
        st_q <= sync;
      end
    end

    assign stable = st_q;
  end else begin : g_deb
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST =
      CW'(DEBOUNCE_CYCLES - 1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic [CW-1:0] cnt_q;
      logic          st_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_q <= '0;
          st_q  <= 1'b0;
        end else if (sync[i] == st_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
          st_q  <= sync[i];
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end

      assign stable[i] = st_q;
    end
  end

  assign rise = stable & ~prev_q;
  assign fall = ~stable & prev_q;

  assign edge_det = (EDGE_TYPE == 0) ? rise :
                    (EDGE_TYPE == 1) ? fall :
                    (rise | fall);

  assign wr_en  = chipselect & ~write_n;
  assign wr_clr = (wr_en && address == 2'd3) ?
                  writedata[WIDTH-1:0] : '0;

  // A new edge outranks a simultaneous W1C of the same bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q    <= '0;
      capture_q <= '0;
    end else begin
      prev_q    <= stable;
      capture_q <= edge_det | (capture_q & ~wr_clr);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
    end else if (wr_en && address == 2'd2) begin
      mask_q <= writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    readdata = '0;
    unique case (address)
      2'd0:    readdata[WIDTH-1:0] = stable;
      2'd2:    readdata[WIDTH-1:0] = mask_q;
      2'd3:    readdata[WIDTH-1:0] = capture_q;
      default: readdata = '0;
    endcase
  end

  assign irq = |(capture_q & mask_q);

  if (WIDTH < 32) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^writedata[31:WIDTH];
  end

endmodule

// File: tb/tb_soc_system_pio_in.sv
// Self-checking bench for soc_system_pio_in.
// Directed scenarios plus a randomized run against a behavioural model.
module tb_soc_system_pio_in;

  localparam int W  = 8;
  localparam int SS = 2;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [W-1:0] in_port = '0;
  logic        irq;

  int checks = 0;
  int failures = 0;

  always #10 clk = ~clk;

  soc_system_pio_in #(
    .WIDTH(W),
    .SYNC_STAGES(SS),
    .DEBOUNCE_CYCLES(DB),
    .EDGE_TYPE(0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .in_port(in_port),
    .irq(irq)
  );

  // Behavioural model: inputs delayed by the synchroniser, a bit flips
  // once it has differed from its stable value for DB sampled clocks.
  logic [SS-1:0][W-1:0] m_pipe, m_pipe_n;
  logic [W-1:0] m_stable, m_stable_n;
  logic [W-1:0] m_prev, m_cap, m_cap_n;
  logic [W-1:0] m_mask, m_mask_n, m_clr;
  int m_run [W];
  int m_run_n [W];

  always_comb begin
    m_pipe_n = m_pipe;
    for (int j = SS - 1; j > 0; j--) m_pipe_n[j] = m_pipe[j-1];
    m_pipe_n[0] = in_port;
    m_stable_n = m_stable;
    for (int i = 0; i < W; i++) begin
      m_run_n[i] = 0;
      if (m_pipe[SS-1][i] != m_stable[i]) begin
        m_run_n[i] = m_run[i] + 1;
        if (m_run_n[i] == DB) begin
          m_stable_n[i] = ~m_stable[i];
          m_run_n[i] = 0;
        end
      end
    end
    m_clr = (chipselect && !write_n && address == 2'd3) ?
            writedata[W-1:0] : '0;
    m_cap_n = (m_stable & ~m_prev) | (m_cap & ~m_clr);
    m_mask_n = (chipselect && !write_n && address == 2'd2) ?
               writedata[W-1:0] : m_mask;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pipe   <= '0;
      m_stable <= '0;
      m_prev   <= '0;
      m_cap    <= '0;
      m_mask   <= '0;
      for (int i = 0; i < W; i++) m_run[i] <= 0;
    end else begin
      m_pipe   <= m_pipe_n;
      m_stable <= m_stable_n;
      m_prev   <= m_stable;
      m_cap    <= m_cap_n;
      m_mask   <= m_mask_n;
      for (int i = 0; i < W; i++) m_run[i] <= m_run_n[i];
    end
  end

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {24'd0, m_stable};
      2'd2:    return {24'd0, m_mask};
      2'd3:    return {24'd0, m_cap};
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    address = a;
    writedata = v;
    chipselect = 1'b1;
    write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    in_port = 8'hFF;
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      checks++;
      if (d !== 32'd0) begin
        failures++;
        $display("FAIL reset_reg%0d got=%h exp=0", a, d);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_irq got=%b exp=0", irq);
    end
    tick(5);
    rd(2'd0, d);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("FAIL reset_data_early got=%h exp=0", d);
    end
    tick(1);
    rd(2'd0, d);
    checks++;
    if (d !== 32'hFF) begin
      failures++;
      $display("FAIL reset_data got=%h exp=ff", d);
    end
    tick(2);
    rd(2'd3, d);
    checks++;
    if (d !== 32'hFF) begin
      failures++;
      $display("FAIL reset_capture got=%h exp=ff", d);
    end
  endtask

  task automatic test_latency();
    logic [31:0] d;
    logic [31:0] e;
    in_port = 8'h00;
    tick(8);
    wr(2'd3, 32'hFF);
    rd(2'd3, d);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("FAIL lat_clear got=%h exp=0", d);
    end
    in_port = 8'h05;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      rd(2'd0, d);
      e = (k >= 6) ? 32'h05 : 32'h00;
      checks++;
      if (d !== e) begin
        failures++;
        $display("FAIL lat_data_e%0d got=%h exp=%h", k, d, e);
      end
      rd(2'd3, d);
      e = (k >= 7) ? 32'h05 : 32'h00;
      checks++;
      if (d !== e) begin
        failures++;
        $display("FAIL lat_cap_e%0d got=%h exp=%h", k, d, e);
      end
      checks++;
      if (irq !== 1'b0) begin
        failures++;
        $display("FAIL lat_irq_e%0d got=%b exp=0", k, irq);
      end
    end
    in_port = 8'h00;
    tick(10);
    rd(2'd3, d);
    checks++;
    if (d !== 32'h05) begin
      failures++;
      $display("FAIL lat_fall_cap got=%h exp=05", d);
    end
    wr(2'd3, 32'hFF);
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    in_port = 8'h01;
    tick(3);
    in_port = 8'h00;
    tick(10);
    rd(2'd0, d);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("FAIL glitch_data got=%h exp=0", d);
    end
    rd(2'd3, d);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("FAIL glitch_cap got=%h exp=0", d);
    end
    in_port = 8'h01;
    tick(4);
    in_port = 8'h00;
    tick(2);
    rd(2'd0, d);
    checks++;
    if (d !== 32'h01) begin
      failures++;
      $display("FAIL accept_data got=%h exp=01", d);
    end
    tick(10);
    rd(2'd3, d);
    checks++;
    if (d !== 32'h01) begin
      failures++;
      $display("FAIL accept_cap got=%h exp=01", d);
    end
    wr(2'd3, 32'hFF);
  endtask

  task automatic test_irq();
    logic [31:0] d;
    wr(2'd2, 32'h01);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_idle got=%b exp=0", irq);
    end
    in_port = 8'h01;
    tick(8);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_set got=%b exp=1", irq);
    end
    wr(2'd3, 32'h00);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_w0 got=%b exp=1", irq);
    end
    wr(2'd3, 32'h01);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_w1c got=%b exp=0", irq);
    end
    rd(2'd2, d);
    checks++;
    if (d !== 32'h01) begin
      failures++;
      $display("FAIL irq_mask got=%h exp=01", d);
    end
    in_port = 8'h00;
    tick(10);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_fall got=%b exp=0", irq);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    in_port = 8'h08;
    tick(6);
    rd(2'd3, d);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("FAIL coll_pre got=%h exp=0", d);
    end
    wr(2'd3, 32'h08);
    rd(2'd3, d);
    checks++;
    if (d !== 32'h08) begin
      failures++;
      $display("FAIL coll_cap got=%h exp=08", d);
    end
  endtask

  task automatic test_midreset();
    logic [31:0] d;
    in_port = 8'h09;
    tick(4);
    reset_n = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      checks++;
      if (d !== 32'd0) begin
        failures++;
        $display("FAIL mrst_reg%0d got=%h exp=0", a, d);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL mrst_irq got=%b exp=0", irq);
    end
    tick(2);
    reset_n = 1'b1;
    tick(5);
    rd(2'd0, d);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("FAIL mrst_data_early got=%h exp=0", d);
    end
    tick(1);
    rd(2'd0, d);
    checks++;
    if (d !== 32'h09) begin
      failures++;
      $display("FAIL mrst_data got=%h exp=09", d);
    end
    tick(1);
    rd(2'd3, d);
    checks++;
    if (d !== 32'h09) begin
      failures++;
      $display("FAIL mrst_cap got=%h exp=09", d);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [31:0] e;
    logic        ei;
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 5) == 0)
        in_port = in_port ^ (8'd1 << $urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0: begin
          address = 2'd2;
          chipselect = 1'b1;
          write_n = 1'b0;
        end
        1: begin
          address = 2'd3;
          chipselect = 1'b1;
          write_n = 1'b0;
        end
        2: begin
          address = 2'($urandom_range(0, 1));
          chipselect = 1'b1;
          write_n = 1'b0;
        end
        3: begin
          address = 2'd3;
          chipselect = 1'b0;
          write_n = 1'b0;
        end
        default: ;
      endcase
      writedata = $urandom;
      tick(1);
      chipselect = 1'b0;
      write_n = 1'b1;
      for (int a = 0; a < 4; a++) begin
        rd(2'(a), d);
        e = exp_rd(2'(a));
        checks++;
        if (d !== e) begin
          failures++;
          $display("FAIL rand_reg%0d it=%0d got=%h exp=%h",
                   a, it, d, e);
        end
      end
      ei = |(m_cap & m_mask);
      checks++;
      if (irq !== ei) begin
        failures++;
        $display("FAIL rand_irq it=%0d got=%b exp=%b", it, irq, ei);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_irq();
    test_collision();
    test_midreset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
